fft_frame_arbiter: RTL and testbench

FFT_FRAME_ARBITER -- requirements
Module: fft_frame_arbiter

---
 rtl/fft_frame_arbiter_pkg.sv | 24 ++
 rtl/fft_frame_arbiter_rr_arb2.sv | 47 ++++
 rtl/fft_frame_arbiter.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_fft_frame_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_frame_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared constants and types for the FFT frame arbiter slice.
//   NPT    : FFT frame length in samples (only 64 is supported)
//   DW     : default width of one signed real/imag sample component
//   IDX_W  : width of bin / buffer indices (log2 of NPT)
//   state_t: frame arbiter FSM states
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int NPT   = 64;
    localparam int DW    = 8;
    localparam int IDX_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_FEED  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

endpackage

// File: rtl/fft_frame_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// fft_rr_arb2
// Two-way round-robin arbiter with a last-served pointer.  The grant is a
// combinational pick from the current requests; the pointer only moves when
// the owner of the grant reports that its frame is finished.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   req      : request vector, one bit per requester
//   update   : pulse when the served requester finishes
//   served   : index of the requester that just finished
//   gnt      : one-hot pick (all zero when nothing is requested)
// ---------------------------------------------------------------------------
module fft_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic [1:0] gnt
);
    import fft_pkg::*;

    logic last_q;
    logic last_d;

    // On a tie the requester that was not served last wins; out of reset
    // requester 1 counts as last served so requester 0 wins the first tie.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        last_d = update ? served : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fft_frame_arbiter.sv
// ---------------------------------------------------------------------------
// fft_frame_arbiter
// Shares one FFT core between two frame sources.  A granted requester loads
// a 64-sample frame into a local buffer, the buffer is streamed into the
// core after a one-cycle start strobe, and the core's result is forwarded
// on the out_* stream tagged with the owning requester and bin index.
// Optional feature: define FFT_ARB_TIMEOUT_EN to bound the wait for the
// core's result; on expiry the core is reset and a sticky timeout is set.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   req / gnt                : frame requests, one-hot grant (held per frame)
//   sN_valid/re/im/ready     : per-requester sample load handshake
//   fft_in_en/re/im          : start strobe and samples towards the core
//   fft_out_en/re/im         : result strobe and samples from the core
//   out_valid/re/im/id/idx/last : result stream, no backpressure
//   busy                     : FSM is not idle
//   timeout, fft_rst         : sticky timeout flag, one-cycle core reset
// ---------------------------------------------------------------------------
module fft_frame_arbiter #(
    parameter int NPT         = fft_pkg::NPT,
    parameter int DW          = fft_pkg::DW,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    output logic [1:0]           gnt,
    input  logic                 s0_valid,
    input  logic signed [DW-1:0] s0_re,
    input  logic signed [DW-1:0] s0_im,
    output logic                 s0_ready,
    input  logic                 s1_valid,
    input  logic signed [DW-1:0] s1_re,
    input  logic signed [DW-1:0] s1_im,
    output logic                 s1_ready,
    output logic                 fft_in_en,
    output logic signed [DW-1:0] fft_in_re,
    output logic signed [DW-1:0] fft_in_im,
    input  logic                 fft_out_en,
    input  logic signed [DW-1:0] fft_out_re,
    input  logic signed [DW-1:0] fft_out_im,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 out_id,
    output logic [5:0]           out_idx,
    output logic                 out_last,
    output logic                 busy,
    output logic                 timeout,
    output logic                 fft_rst
);
    import fft_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPT - 1);

    // The pointer and counter widths are fixed at six bits.
    if (NPT != 64) begin : g_bad_npt
        $error("fft_frame_arbiter: only NPT=64 is supported");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 8191) begin : g_bad_timeout
        $error("fft_frame_arbiter: TIMEOUT_CYC must fit the 13-bit wait counter");
    end

    state_t                state_q, state_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            ready_q, ready_d;
    logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]      out_cnt_q, out_cnt_d;
    logic                  fft_in_en_q, fft_in_en_d;
    logic signed [DW-1:0]  fft_in_re_q, fft_in_re_d;
    logic signed [DW-1:0]  fft_in_im_q, fft_in_im_d;
    logic                  fft_out_en_q, fft_out_en_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic signed [DW-1:0]  out_re_q, out_re_d;
    logic signed [DW-1:0]  out_im_q, out_im_d;
    logic [IDX_W-1:0]      out_idx_q, out_idx_d;
    logic                  out_id_q, out_id_d;
    logic                  busy_q, busy_d;
`ifdef FFT_ARB_TIMEOUT_EN
    logic                  timeout_q, timeout_d;
    logic                  fft_rst_q, fft_rst_d;
    logic [12:0]           tmo_cnt_q, tmo_cnt_d;
`endif

    logic [1:0]            rr_gnt;
    logic                  arb_update;
    logic                  load_fire;
    logic [2*DW-1:0]       load_word;
    logic [IDX_W-1:0]      rd_addr;
    logic [2*DW-1:0]       rd_word;
    logic [2*DW-1:0]       buf_mem [NPT];

    fft_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .update (arb_update),
        .served (gnt_q[1]),
        .gnt    (rr_gnt)
    );

    assign load_fire = (state_q == ST_LOAD) &&
                       (gnt_q[0] ? (s0_valid && ready_q[0]) : (s1_valid && ready_q[1]));
    assign load_word = gnt_q[0] ? {s0_re, s0_im} : {s1_re, s1_im};

    // The read is issued one cycle ahead of the FEED beat it serves: entry 0
    // during START, entry p+1 during FEED beat p, so the registered core
    // inputs show entry 0 on the first FEED cycle with no bubble.
    assign rd_addr = (state_q == ST_START) ? '0 : rd_ptr_q + 1'b1;
    assign rd_word = buf_mem[rd_addr];

    // Frame buffer; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            buf_mem[wr_ptr_q] <= load_word;
        end
    end

    // Next-state and registered-output logic for the whole frame sequence.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        ready_d      = ready_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_cnt_d    = out_cnt_q;
        fft_in_re_d  = '0;
        fft_in_im_d  = '0;
        fft_out_en_d = fft_out_en;
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
        out_re_d     = out_re_q;
        out_im_d     = out_im_q;
        out_idx_d    = out_idx_q;
        out_id_d     = out_id_q;
        arb_update   = 1'b0;
`ifdef FFT_ARB_TIMEOUT_EN
        timeout_d    = timeout_q;
        fft_rst_d    = 1'b0;
        tmo_cnt_d    = tmo_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d  = ST_LOAD;
                    gnt_d    = rr_gnt;
                    ready_d  = rr_gnt;
                    wr_ptr_d = '0;
                end
            end
            ST_LOAD: begin
                if (load_fire) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_IDX) begin
                        state_d = ST_START;
                        ready_d = 2'b00;
                    end
                end
            end
            ST_START: begin
                state_d     = ST_FEED;
                rd_ptr_d    = '0;
                fft_in_re_d = rd_word[2*DW-1:DW];
                fft_in_im_d = rd_word[DW-1:0];
            end
            ST_FEED: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (rd_ptr_q == LAST_IDX) begin
                    state_d = ST_WAIT;
`ifdef FFT_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end else begin
                    fft_in_re_d = rd_word[2*DW-1:DW];
                    fft_in_im_d = rd_word[DW-1:0];
                end
            end
            ST_WAIT: begin
                // A result edge in the same cycle as expiry still wins.
                if (fft_out_en && !fft_out_en_q) begin
                    state_d   = ST_DRAIN;
                    out_cnt_d = '0;
                end
`ifdef FFT_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == 13'(TIMEOUT_CYC - 1)) begin
                    state_d    = ST_IDLE;
                    gnt_d      = 2'b00;
                    arb_update = 1'b1;
                    fft_rst_d  = 1'b1;
                    timeout_d  = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            ST_DRAIN: begin
                out_valid_d = 1'b1;
                out_re_d    = fft_out_re;
                out_im_d    = fft_out_im;
                out_idx_d   = out_cnt_q;
                out_id_d    = gnt_q[1];
                out_last_d  = (out_cnt_q == LAST_IDX);
                out_cnt_d   = out_cnt_q + 1'b1;
                if (out_cnt_q == LAST_IDX) begin
                    state_d    = ST_IDLE;
                    gnt_d      = 2'b00;
                    arb_update = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
                ready_d = 2'b00;
            end
        endcase

        fft_in_en_d = (state_d == ST_START);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 2'b00;
            ready_q      <= 2'b00;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            out_cnt_q    <= '0;
            fft_in_en_q  <= 1'b0;
            fft_in_re_q  <= '0;
            fft_in_im_q  <= '0;
            fft_out_en_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_re_q     <= '0;
            out_im_q     <= '0;
            out_idx_q    <= '0;
            out_id_q     <= 1'b0;
            busy_q       <= 1'b0;
`ifdef FFT_ARB_TIMEOUT_EN
            timeout_q    <= 1'b0;
            fft_rst_q    <= 1'b0;
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            ready_q      <= ready_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_cnt_q    <= out_cnt_d;
            fft_in_en_q  <= fft_in_en_d;
            fft_in_re_q  <= fft_in_re_d;
            fft_in_im_q  <= fft_in_im_d;
            fft_out_en_q <= fft_out_en_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_re_q     <= out_re_d;
            out_im_q     <= out_im_d;
            out_idx_q    <= out_idx_d;
            out_id_q     <= out_id_d;
            busy_q       <= busy_d;
`ifdef FFT_ARB_TIMEOUT_EN
            timeout_q    <= timeout_d;
            fft_rst_q    <= fft_rst_d;
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign s0_ready  = ready_q[0];
    assign s1_ready  = ready_q[1];
    assign fft_in_en = fft_in_en_q;
    assign fft_in_re = fft_in_re_q;
    assign fft_in_im = fft_in_im_q;
    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_id    = out_id_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
`ifdef FFT_ARB_TIMEOUT_EN
    assign timeout   = timeout_q;
    assign fft_rst   = fft_rst_q;
`else
    assign timeout   = 1'b0;
    assign fft_rst   = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_arbiter
// Directed bench for fft_frame_arbiter.  A table of frame records (request
// pattern, load gaps, result-strobe glitch, request drop, expected owner) is
// run in a loop; each frame loads re=k/im=-k, captures the core inputs, and
// plays a core model that returns (re,im) swapped.  Hand-written sequences
// cover reset, mid-frame reset and the optional FFT_ARB_TIMEOUT_EN build.
// ---------------------------------------------------------------------------
module tb_fft_frame_arbiter;

    localparam int DW = 8;

    typedef struct {
        logic [1:0] req;
        bit         gap;
        bit         glitch;
        bit         dropReq;
        logic       expId;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req;
    logic [1:0]           gnt;
    logic                 s0_valid, s1_valid, s0_ready, s1_ready;
    logic signed [DW-1:0] s0_re, s0_im, s1_re, s1_im;
    logic                 fft_in_en, fft_out_en;
    logic signed [DW-1:0] fft_in_re, fft_in_im, fft_out_re, fft_out_im;
    logic                 out_valid, out_id, out_last, busy, timeout, fft_rst;
    logic signed [DW-1:0] out_re, out_im;
    logic [5:0]           out_idx;
    logic [48:0]          allOut;

    int checks    = 0;
    int fails     = 0;
    int nInEn     = 0;
    int nOutValid = 0;
    int nFftRst   = 0;

    logic signed [DW-1:0] capRe [64];
    logic signed [DW-1:0] capIm [64];
    vec_t                 vecs [8];

    fft_frame_arbiter #(.NPT(64), .DW(DW), .TIMEOUT_CYC(4096)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .s0_valid   (s0_valid),
        .s0_re      (s0_re),
        .s0_im      (s0_im),
        .s0_ready   (s0_ready),
        .s1_valid   (s1_valid),
        .s1_re      (s1_re),
        .s1_im      (s1_im),
        .s1_ready   (s1_ready),
        .fft_in_en  (fft_in_en),
        .fft_in_re  (fft_in_re),
        .fft_in_im  (fft_in_im),
        .fft_out_en (fft_out_en),
        .fft_out_re (fft_out_re),
        .fft_out_im (fft_out_im),
        .out_valid  (out_valid),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_id     (out_id),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy),
        .timeout    (timeout),
        .fft_rst    (fft_rst)
    );

    always #5 clk = ~clk;

    assign allOut = {gnt, s0_ready, s1_ready, fft_in_en, fft_in_re, fft_in_im,
                     out_valid, out_last, out_re, out_im, out_idx, out_id,
                     busy, timeout, fft_rst};

    // Running totals of strobe cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (fft_in_en) nInEn++;
        if (out_valid) nOutValid++;
        if (fft_rst)   nFftRst++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitGrant(input logic [1:0] reqVal, output int waited);
        req    = reqVal;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (gnt == 2'b00 && waited < 20);
    endtask

    // Offers 64 beats to the granted port; the other port offers junk the
    // whole time, which must never be accepted.
    task automatic loadFrame(input logic id, input bit gap, output int cyc);
        int k = 0;
        int leakErr = 0;
        bit vNow;
        bit rNow;
        cyc = 0;
        while (k < 64 && cyc < 400) begin
            vNow = gap ? (cyc % 2 == 0) : 1'b1;
            if (id == 1'b0) begin
                s0_valid = vNow; s0_re = DW'(k); s0_im = DW'(-k);
                s1_valid = 1'b1; s1_re = 8'sh7f; s1_im = 8'sh7f;
                rNow = s0_ready;
                if (s1_ready) leakErr++;
            end else begin
                s1_valid = vNow; s1_re = DW'(k); s1_im = DW'(-k);
                s0_valid = 1'b1; s0_re = 8'sh7f; s0_im = 8'sh7f;
                rNow = s1_ready;
                if (s0_ready) leakErr++;
            end
            tick();
            cyc++;
            if (vNow && rNow) k++;
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        checkOutput("load_beats", k, 64);
        checkOutput("other_ready", leakErr, 0);
    endtask

    task automatic feedCapture(input bit glitch, output int feedErr);
        feedErr = 0;
        for (int j = 0; j < 64; j++) begin
            tick();
            capRe[j] = fft_in_re;
            capIm[j] = fft_in_im;
            if (fft_in_re !== DW'(j) || fft_in_im !== DW'(-j) || fft_in_en !== 1'b0)
                feedErr++;
            if (glitch && j == 10) fft_out_en = 1'b1;
            if (glitch && j == 12) fft_out_en = 1'b0;
        end
    endtask

    // Core model: one rising edge of fft_out_en, then 64 result samples on
    // consecutive cycles, each sample being the captured input with re/im
    // swapped, so bin j carries re=-j, im=j.
    task automatic drainCheck(input logic id);
        int out0;
        logic [24:0] act;
        logic [24:0] exp;
        out0 = nOutValid;
        repeat (4) tick();
        checkOutput("wait_quiet", nOutValid - out0, 0);
        checkOutput("wait_busy", busy, 1);
        fft_out_en = 1'b1;
        tick();
        checkOutput("no_early_beat", out_valid, 0);
        fft_out_re = capIm[0];
        fft_out_im = capRe[0];
        for (int j = 1; j <= 64; j++) begin
            tick();
            act = {out_valid, out_id, out_idx, out_last, out_re, out_im};
            exp = {1'b1, id, 6'(j - 1), (j == 64), DW'(-(j - 1)), DW'(j - 1)};
            checkOutput($sformatf("beat%0d", j - 1), act, exp);
            if (j < 64) begin
                fft_out_re = capIm[j];
                fft_out_im = capRe[j];
            end
        end
        fft_out_en = 1'b0;
        fft_out_re = '0;
        fft_out_im = '0;
        checkOutput("frame_end_idle", {busy, gnt}, 0);
        checkOutput("beat_count", nOutValid - out0, 64);
    endtask

    task automatic applyStimulus(input vec_t v);
        int waited;
        int cyc;
        int feedErr;
        int inEn0;
        waitGrant(v.req, waited);
        checkOutput("grant", gnt, v.expId ? 2'b10 : 2'b01);
        checkOutput("idle_gap", waited, 1);
        if (gnt == 2'b00) return;
        if (v.dropReq) req = 2'b00;
        inEn0 = nInEn;
        loadFrame(v.expId, v.gap, cyc);
        checkOutput("load_cycles", cyc, v.gap ? 127 : 64);
        checkOutput("start_pulse", {fft_in_en, s0_ready, s1_ready, gnt}, {3'b100, v.expId ? 2'b10 : 2'b01});
        feedCapture(v.glitch, feedErr);
        checkOutput("feed_data", feedErr, 0);
        checkOutput("in_en_pulses", nInEn - inEn0, 1);
        drainCheck(v.expId);
    endtask

    initial begin
        int waited;
        int cyc;
        int feedErr;
        vec_t resetVec;

        //          req    gap   glitch drop  id
        vecs[0] = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{2'b10, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
        resetVec = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; req = 2'b00;
        s0_valid = 1'b0; s0_re = '0; s0_im = '0;
        s1_valid = 1'b0; s1_re = '0; s1_im = '0;
        fft_out_en = 1'b0; fft_out_re = '0; fft_out_im = '0;
        repeat (3) tick();
        checkOutput("reset_outputs", allOut, 0);
        rst = 1'b0;
        repeat (2) tick();
        checkOutput("idle_after_reset", {busy, gnt, s0_ready, s1_ready}, 0);

        for (int i = 0; i < 8; i++) begin
            $display("[TB] frame %0d req=%b", i, vecs[i].req);
            applyStimulus(vecs[i]);
        end
        req = 2'b00;
        repeat (3) tick();
        checkOutput("stay_idle", {busy, gnt}, 0);

        // Reset in the middle of FEED, then a tie must go to requester 0.
        waitGrant(2'b01, waited);
        req = 2'b00;
        loadFrame(1'b0, 1'b0, cyc);
        repeat (31) tick();
        checkOutput("feed_beat30", {fft_in_re, fft_in_im}, {8'sd30, -8'sd30});
        rst = 1'b1;
        #1;
        checkOutput("async_reset", allOut, 0);
        tick();
        rst = 1'b0;
        tick();
        applyStimulus(resetVec);
        req = 2'b00;
        tick();

`ifdef FFT_ARB_TIMEOUT_EN
        begin
            int n = 0;
            int out0;
            int rst0;
            waitGrant(2'b01, waited);
            req = 2'b00;
            loadFrame(1'b0, 1'b0, cyc);
            feedCapture(1'b0, feedErr);
            out0 = nOutValid;
            rst0 = nFftRst;
            do begin
                tick();
                n++;
            end while (fft_rst !== 1'b1 && n < 5000);
            checkOutput("timeout_cycles", n, 4097);
            checkOutput("timeout_state", {timeout, busy, gnt}, 4'b1000);
            tick();
            checkOutput("fft_rst_pulse", {fft_rst, timeout}, 2'b01);
            checkOutput("fft_rst_count", nFftRst - rst0, 1);
            checkOutput("timeout_no_beats", nOutValid - out0, 0);
        end
`else
        checkOutput("timeout_tied", {timeout, fft_rst}, 0);
        checkOutput("no_core_reset", nFftRst, 0);
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
